matrix_serializer: RTL
======================

MATRIX_SERIALIZER -- requirements
Module: matrix_serializer

Interface
REQ-001 Parameter DWIDTH, default 4: width of one matrix element in bits.
REQ-002 Parameter SIZE, default 16: elements per packed word; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  in_data holds a packed word.
REQ-006 in_ready  output  1  block accepts a word this cycle.
REQ-007 in_data  input  SIZE*DWIDTH  packed word; element k occupies bits [k*DWIDTH +: DWIDTH].
REQ-008 out_valid  output  1  out_data holds a valid element.
REQ-009 out_ready  input  1  downstream consumes the element this cycle.
REQ-010 out_data  output  DWIDTH  current element.
REQ-011 out_last  output  1  out_data is the final element of the current word.

Function
REQ-012 Word transfer SHALL occur when in_valid and in_ready are both high at a clock edge; element transfer SHALL occur when out_valid and out_ready are both high at a clock edge.
REQ-013 Storage SHALL be one shift register with element counter cnt (log2(SIZE) bits) and busy flag, plus one pending-word register with pend_valid flag.
REQ-014 in_ready SHALL equal !pend_valid (combinational, no dependence on in_valid).
REQ-015 out_valid SHALL equal busy; out_data SHALL be the low DWIDTH bits of the shift register; out_last SHALL be busy && cnt==SIZE-1.
REQ-016 On each element transfer that is not last, the shift register SHALL shift right by DWIDTH and cnt SHALL increment.
REQ-017 States: IDLE (busy=0), SHIFT (busy=1, pend_valid=0), FULL (busy=1, pend_valid=1).
REQ-018 IDLE: an accepted word SHALL load the shift register with cnt=0; first element valid the next cycle (latency 1).
REQ-019 SHIFT, accepted word without last transfer: word SHALL go to the pending register -> FULL.
REQ-020 SHIFT, last transfer with simultaneous accepted word: the word SHALL load the shift register directly, cnt=0; no bubble.
REQ-021 SHIFT, last transfer with no word: -> IDLE.
REQ-022 FULL, last transfer: the pending word SHALL move into the shift register, cnt=0, pend_valid cleared; in_ready high the following cycle.
REQ-023 With out_ready held high, a continuous stream SHALL emit one element per cycle with no gaps between words.
REQ-024 With out_ready low, out_data, out_last and all state SHALL hold.
REQ-025 Words SHALL be emitted in acceptance order; no word dropped or duplicated.

Reset
REQ-026 rst high SHALL clear busy, pend_valid, cnt, shift register and pending register; after reset out_valid=0, out_last=0, out_data=0, in_ready=1.
REQ-027 rst asserted mid-word SHALL discard the in-flight and pending words; no element of them SHALL appear after reset.

Configuration
REQ-028 Macro MATRIX_SERIALIZER_MSB_FIRST_EN: when defined, elements SHALL be emitted from index SIZE-1 down to 0 (left shift, out_data = top DWIDTH bits); when undefined, emitted from index 0 up to SIZE-1.
REQ-029 Handshake, latency and out_last timing SHALL be identical with and without the macro.

Structure
REQ-030 A shared package SHALL hold the state encoding (IDLE/SHIFT/FULL) and the counter width derived as log2(SIZE).
REQ-031 The shift register with its counter SHALL be one sub-module, matrix_shift_unit; the top holds the pending register and control.

Verification
REQ-032 Single word 0xFEDCBA9876543210, out_ready=1, macro off -> out_data 0,1,...,F on 16 consecutive cycles starting 1 cycle after accept; out_last only with F.
REQ-033 Same word, macro on -> out_data F,E,...,0; out_last only with 0.
REQ-034 Back-to-back words A=0x1111..., B=0x2222..., in_valid held, out_ready=1 -> 32 consecutive valid cycles, sixteen 1s then sixteen 2s; in_ready low from second cycle until B enters the shifter.
REQ-035 out_ready toggled 1,0 alternately over one word -> each element held while out_ready=0; full word emitted in 32 cycles, order intact.
REQ-036 rst pulsed after 5 elements of word A with word B pending -> out_valid=0 and in_ready=1 the cycle after reset; next accepted word C emits all 16 elements, none from A or B.

Source files
------------

// File: rtl/matrix_serializer_pkg.sv
// -----------------------------------------------------------------------------
// matrix_serializer_pkg
// Shared definitions for the matrix serializer: the control state encoding and
// the element-counter width helper used by the top and the shift unit.
// -----------------------------------------------------------------------------
package matrix_serializer_pkg;

   // IDLE : shifter empty
   // SHIFT: shifter emitting a word, pending register empty
   // FULL : shifter emitting a word, pending register holds the next word
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FULL  = 2'd2
   } state_t;

   localparam int DEFAULT_SIZE = 16;

   // Element counter width: log2 of the number of elements per word.
   function automatic int cnt_width(input int size);
      return (size < 2) ? 1 : $clog2(size);
   endfunction

endpackage

// File: rtl/matrix_shift_unit.sv
// -----------------------------------------------------------------------------
// matrix_shift_unit
// Shift register holding the word currently being emitted, plus the element
// counter. Emission order is selected by MATRIX_SERIALIZER_MSB_FIRST_EN:
//   undefined -> right shift, element 0 first (out of the low bits)
//   defined   -> left shift, element SIZE-1 first (out of the high bits)
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   load       load load_data into the shifter, counter to 0
//   load_data  packed word to load
//   advance    step to the next element (shift + counter increment)
//   elem       element currently presented
//   cnt        index of the element currently presented (emission order)
// -----------------------------------------------------------------------------
module matrix_shift_unit
   import matrix_serializer_pkg::*;
#(
   parameter int DWIDTH = 4,
   parameter int SIZE   = DEFAULT_SIZE,
   parameter int CW     = cnt_width(SIZE)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic [SIZE*DWIDTH-1:0] load_data,
   input  logic                   advance,
   output logic [DWIDTH-1:0]      elem,
   output logic [CW-1:0]          cnt
);

   logic [SIZE*DWIDTH-1:0] sreg;

   // Advancing past the last element wraps cnt to 0 (SIZE is a power of two)
   // and shifts zeros in, so an idle shifter presents out_data = 0.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         sreg <= '0;
         cnt  <= '0;
      end else if (load) begin
         sreg <= load_data;
         cnt  <= '0;
      end else if (advance) begin
`ifdef MATRIX_SERIALIZER_MSB_FIRST_EN
         sreg <= sreg << DWIDTH;
`else
         sreg <= sreg >> DWIDTH;
`endif
         cnt  <= cnt + CW'(1);
      end
   end

`ifdef MATRIX_SERIALIZER_MSB_FIRST_EN
   assign elem = sreg[SIZE*DWIDTH-1 -: DWIDTH];
`else
   assign elem = sreg[DWIDTH-1:0];
`endif

endmodule

// File: rtl/matrix_serializer.sv
// -----------------------------------------------------------------------------
// matrix_serializer
// Accepts packed words of SIZE elements (DWIDTH bits each) and emits them one
// element per transfer, with a one-word pending buffer so a new word can be
// taken while the current one drains and streaming continues without gaps.
// Optional macro: MATRIX_SERIALIZER_MSB_FIRST_EN (emit highest index first).
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   in_valid    in_data holds a packed word
//   in_ready    a word can be accepted this cycle
//   in_data     packed word, element k at [k*DWIDTH +: DWIDTH]
//   out_valid   out_data holds a valid element
//   out_ready   downstream takes the element this cycle
//   out_data    current element
//   out_last    current element is the final one of its word
// -----------------------------------------------------------------------------
module matrix_serializer
   import matrix_serializer_pkg::*;
#(
   parameter int DWIDTH = 4,
   parameter int SIZE   = DEFAULT_SIZE
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [SIZE*DWIDTH-1:0] in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DWIDTH-1:0]      out_data,
   output logic                   out_last
);

   localparam int CW = cnt_width(SIZE);

   state_t                 state, state_nxt;
   logic [SIZE*DWIDTH-1:0] pend;
   logic [CW-1:0]          cnt;
   logic                   busy, pend_valid;
   logic                   accept, xfer, last_xfer;
   logic                   load, sel_pend, pend_we;

   assign busy       = (state != IDLE);
   assign pend_valid = (state == FULL);

   assign in_ready   = !pend_valid;
   assign out_valid  = busy;
   assign out_last   = busy && (cnt == CW'(SIZE - 1));

   assign accept     = in_valid && in_ready;
   assign xfer       = out_valid && out_ready;
   assign last_xfer  = xfer && out_last;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SHIFT;
         SHIFT: begin
            if (last_xfer) state_nxt = accept ? SHIFT : IDLE;
            else if (accept) state_nxt = FULL;
         end
         FULL:    if (last_xfer) state_nxt = SHIFT;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath controls. A word goes straight into the shifter whenever the
   // shifter is (or is about to become) free; otherwise it is parked.
   // NOTE: every combinational output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      load     = 1'b0;
      sel_pend = 1'b0;
      pend_we  = 1'b0;
      case (state)
         IDLE:  load = accept;
         SHIFT: begin
            load    = accept && last_xfer;
            pend_we = accept && !last_xfer;
         end
         FULL: begin
            load     = last_xfer;
            sel_pend = 1'b1;
         end
         default: ;
      endcase
   end

   // Pending word register.
   // NOTE: the data register is reset as well as its valid flag, so a discarded
   // word never lingers in the datapath after reset.
   always_ff @(posedge clk) begin
      if (rst)          pend <= '0;
      else if (pend_we) pend <= in_data;
   end

   matrix_shift_unit #(
      .DWIDTH (DWIDTH),
      .SIZE   (SIZE),
      .CW     (CW)
   ) u_shift (
      .clk       (clk),
      .rst       (rst),
      .load      (load),
      .load_data (sel_pend ? pend : in_data),
      .advance   (xfer && !load),
      .elem      (out_data),
      .cnt       (cnt)
   );

endmodule
